// File: rtl/seq_matrix_multiplier.sv
// Sequential N x N matrix multiplier: C = A x B, one multiply-accumulate per cycle,
// results streamed out in row-major order over a valid/ready handshake.
module seq_matrix_multiplier #(
    parameter int unsigned N      = 4,
    parameter int unsigned W      = 3,
    parameter bit          SIGNED = 1'b0,
    localparam int unsigned AW    = $clog2(N),
    localparam int unsigned OW    = 2 * W + AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_row,
    input  logic [AW-1:0] wr_col,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [OW-1:0] res_data,
    output logic [AW-1:0] res_row,
    output logic [AW-1:0] res_col,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q [N][N];
    logic [W-1:0]  b_q [N][N];
    logic [AW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] res_data_q, res_data_d;
    logic [AW-1:0] res_row_q, res_row_d, res_col_q, res_col_d;
    logic          busy_q, busy_d, res_valid_q, res_valid_d, done_q, done_d;
    logic [OW-1:0] prod;
    logic [OW-1:0] acc_sum;
    logic          k_last, elem_last, hs;

    // Widen an operand to result precision, sign-extending in two's-complement mode.
    function automatic logic [OW-1:0] widen(input logic [W-1:0] v);
        if (SIGNED) begin
            return {{(OW - W){v[W-1]}}, v};
        end
        return {{(OW - W){1'b0}}, v};
    endfunction

    assign prod      = widen(a_q[i_q][k_q]) * widen(b_q[k_q][j_q]);
    assign acc_sum   = acc_q + prod;
    assign k_last    = (k_q == LAST_IDX);
    assign elem_last = (i_q == LAST_IDX) && (j_q == LAST_IDX);
    assign hs        = res_valid_q && res_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)  state_d = MAC;
            MAC:     if (k_last) state_d = HOLD;
            HOLD:    if (hs)     state_d = elem_last ? FIN : MAC;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; status flags are decoded from the next state
    // so the registered copies line up exactly with the state they describe.
    always_comb begin
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_row_d   = res_row_q;
        res_col_d   = res_col_q;
        busy_d      = (state_d == MAC) || (state_d == HOLD);
        res_valid_d = (state_d == HOLD);
        done_d      = (state_d == FIN);
        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d   = '0;
                    j_d   = '0;
                    k_d   = '0;
                    acc_d = '0;
                end
            end
            MAC: begin
                if (k_last) begin
                    res_data_d = acc_sum;
                    res_row_d  = i_q;
                    res_col_d  = j_q;
                    acc_d      = '0;
                    k_d        = '0;
                end else begin
                    acc_d = acc_sum;
                    k_d   = k_q + AW'(1);
                end
            end
            HOLD: begin
                if (hs) begin
                    if (j_q == LAST_IDX) begin
                        j_d = '0;
                        i_d = i_q + AW'(1);
                    end else begin
                        j_d = j_q + AW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            res_row_q   <= '0;
            res_col_q   <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_row_q   <= res_row_d;
            res_col_q   <= res_col_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    // Operand storage; writes are locked out while a multiply is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(N); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else if (wr_en && !busy_q) begin
            if (!wr_sel) begin
                a_q[wr_row][wr_col] <= wr_data;
            end else begin
                b_q[wr_row][wr_col] <= wr_data;
            end
        end
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_row   = res_row_q;
    assign res_col   = res_col_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_matrix_multiplier.sv
// Bench for seq_matrix_multiplier: directed and random matrices checked against
// a plain-arithmetic matrix product, including backpressure, busy lockout and reset abort.
module tb_seq_matrix_multiplier;

    localparam int unsigned N      = 4;
    localparam int unsigned W      = 3;
    localparam int unsigned AW     = $clog2(N);
    localparam int unsigned OW     = 2 * W + AW;
    localparam int          BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_row = '0;
    logic [AW-1:0] wr_col = '0;
    logic [W-1:0]  wr_data = '0;
    logic          start = 1'b0;
    logic          res_ready = 1'b1;

    logic          u_busy, u_valid, u_done, s_busy, s_valid, s_done;
    logic [OW-1:0] u_data, s_data;
    logic [AW-1:0] u_row, u_col, s_row, s_col;

    int n_checks = 0;
    int n_fail   = 0;
    int ma [N][N];
    int mb [N][N];

    seq_matrix_multiplier #(.N(N), .W(W), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(u_busy),
        .res_valid(u_valid), .res_ready(res_ready), .res_data(u_data),
        .res_row(u_row), .res_col(u_col), .done(u_done)
    );

    seq_matrix_multiplier #(.N(N), .W(W), .SIGNED(1'b1)) s_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(s_busy),
        .res_valid(s_valid), .res_ready(res_ready), .res_data(s_data),
        .res_row(s_row), .res_col(s_col), .done(s_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_op(input bit sel, input int r, input int c, input int v);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = AW'(r);
        wr_col  = AW'(c);
        wr_data = W'(v);
        tick();
        wr_en = 1'b0;
        if (sel) mb[r][c] = v; else ma[r][c] = v;
    endtask

    // mode 0: constant fill, 1: A[r][c]=r+c with B=identity, 2: random
    task automatic load_ops(input int mode, input int va, input int vb);
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                int a, b;
                a = (mode == 0) ? va : (mode == 1) ? r + c : int'($urandom_range(0, (1 << W) - 1));
                b = (mode == 0) ? vb : (mode == 1) ? int'(r == c) : int'($urandom_range(0, (1 << W) - 1));
                write_op(1'b0, r, c, a);
                write_op(1'b1, r, c, b);
            end
        end
    endtask

    function automatic int as_val(input int v, input bit sgn);
        if (sgn && (((v >> (W - 1)) & 1) == 1)) return v - (1 << W);
        return v;
    endfunction

    // Run one multiply; optionally stall, inject a write+start, or reset at a given element.
    task automatic run_mult(input bit sgn, input int stall_e, input int inj_e,
                            input int abort_e, input bit timing);
        int cexp [N][N];
        int e, cyc, stall;
        bit seen;
        logic [31:0] obs, expv;
        logic vld, dn, bsy;
        string etag;
        etag = sgn ? "elem_signed" : "elem";
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                cexp[r][c] = 0;
                for (int k = 0; k < int'(N); k++)
                    cexp[r][c] += as_val(ma[r][k], sgn) * as_val(mb[k][c], sgn);
            end
        end
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        chk("busy_after_start", 32'(sgn ? s_busy : u_busy), 32'd1);
        e = 0;
        seen = 1'b0;
        stall = 0;
        while (e < int'(N * N) && cyc < BUDGET) begin
            vld = sgn ? s_valid : u_valid;
            if (vld) begin
                obs  = sgn ? 32'({s_row, s_col, s_data}) : 32'({u_row, u_col, u_data});
                expv = 32'({AW'(e / int'(N)), AW'(e % int'(N)),
                            OW'(cexp[e / int'(N)][e % int'(N)])});
                if (!seen) begin
                    chk(etag, obs, expv);
                    seen = 1'b1;
                    if (timing && e == 0) chk("first_valid_cycle", 32'(cyc), 32'(N + 1));
                    if (e == abort_e) begin
                        rst = 1'b1;
                        tick();
                        rst = 1'b0;
                        chk("abort_flags", 32'({u_busy, u_valid, u_done}), 32'd0);
                        chk("abort_result_regs", 32'({u_row, u_col, u_data}), 32'd0);
                        tick();
                        chk("abort_stays_idle", 32'({u_busy, u_valid}), 32'd0);
                        return;
                    end
                    if (e == inj_e) begin
                        wr_en   = 1'b1;
                        wr_sel  = 1'b0;
                        wr_row  = '0;
                        wr_col  = '0;
                        wr_data = W'(5);
                        start   = 1'b1;
                    end
                end else begin
                    chk("hold_stable", {31'd0, vld} << 12 | obs, 32'd1 << 12 | expv);
                end
                if (e == stall_e && stall < 5) begin
                    res_ready = 1'b0;
                    stall++;
                end else begin
                    res_ready = 1'b1;
                end
            end
            tick();
            cyc++;
            wr_en = 1'b0;
            start = 1'b0;
            if (res_ready && seen) begin
                e++;
                seen = 1'b0;
            end
        end
        chk("all_elements_seen", 32'(e), 32'(N * N));
        dn = sgn ? s_done : u_done;
        while (!dn && cyc < BUDGET) begin
            tick();
            cyc++;
            dn = sgn ? s_done : u_done;
        end
        bsy = sgn ? s_busy : u_busy;
        chk("done_with_busy_low", 32'({dn, bsy}), 32'b10);
        if (timing) chk("done_cycle", 32'(cyc), 32'(N * N * (N + 1) + 1));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_done_ignored", 32'(sgn ? {s_done, s_busy, s_valid} : {u_done, u_busy, u_valid}), 32'd0);
    endtask

    initial begin
        // Reset with write and start asserted: reset must win.
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_data = W'(7);
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        chk("reset_flags", 32'({u_busy, u_valid, u_done}), 32'd0);
        chk("reset_result_regs", 32'({u_row, u_col, u_data}), 32'd0);
        tick();
        chk("idle_after_reset", 32'(u_busy), 32'd0);

        load_ops(0, 7, 7);
        run_mult(1'b0, -1, -1, -1, 1'b1);

        load_ops(1, 0, 0);
        run_mult(1'b0, -1, -1, -1, 1'b1);

        load_ops(2, 0, 0);
        run_mult(1'b0, 1 * int'(N) + 2, -1, -1, 1'b0);

        load_ops(2, 0, 0);
        run_mult(1'b0, -1, 3, -1, 1'b0);
        run_mult(1'b0, -1, -1, -1, 1'b1);

        load_ops(2, 0, 0);
        run_mult(1'b0, -1, -1, 2 * int'(N) + 1, 1'b0);
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                ma[r][c] = 0;
                mb[r][c] = 0;
            end
        run_mult(1'b0, -1, -1, -1, 1'b1);
        load_ops(2, 0, 0);
        run_mult(1'b0, -1, -1, -1, 1'b1);

        load_ops(0, 4, 3);
        run_mult(1'b1, -1, -1, -1, 1'b1);
        load_ops(2, 0, 0);
        run_mult(1'b1, 5, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_matrix_multiplier.md
SEQ_MATRIX_MULTIPLIER -- requirements
Module: seq_matrix_multiplier

Interface
REQ-001 Parameter N, default 4: matrix dimension (N x N); legal values are 2, 4, 8, 16.
REQ-002 Parameter W, default 3: element width in bits.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-004 Derived AW = clog2(N) and OW = 2*W + AW; OW is the result width.
REQ-005 Design SHALL use one clock (clk); reset is synchronous and active-high (rst).
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  operand write strobe.
REQ-009 wr_sel  input  1  operand target: 0 = matrix A, 1 = matrix B.
REQ-010 wr_row, wr_col  input  AW each  operand element address.
REQ-011 wr_data  input  W  operand element value.
REQ-012 start  input  1  launch a multiply of the stored A and B (C = A x B).
REQ-013 busy  output  1  high from the cycle after an accepted start until done.
REQ-014 res_valid  output  1  result element available.
REQ-015 res_ready  input  1  downstream accepts the result element.
REQ-016 res_data  output  OW  C[res_row][res_col].
REQ-017 res_row, res_col  output  AW each  index of res_data.
REQ-018 done  output  1  one-cycle pulse after the final element handshake.

Function
REQ-019 A and B SHALL be stored in internal N*N*W-bit register arrays; a write occurs on a clk edge when wr_en=1 and busy=0.
REQ-020 A write while busy=1 SHALL be ignored; the stored operands SHALL remain unchanged.
REQ-021 start is accepted when busy=0 and the FSM is in IDLE; start while busy=1 SHALL be ignored.
REQ-022 FSM states: IDLE, MAC, HOLD, FIN.
REQ-023 FSM transitions:
- IDLE->MAC on an accepted start, with i=j=k=0 and acc=0.
- MAC->HOLD after the k=N-1 product is accumulated.
- HOLD->MAC (next element) on res_valid&&res_ready when the element is not the last.
- HOLD->FIN on that handshake for element (N-1,N-1).
- FIN->IDLE unconditionally.
REQ-024 MAC SHALL perform one multiply-accumulate per cycle: acc += A[i][k]*B[k][j], k incrementing 0..N-1; acc SHALL be cleared on entry to each element.
REQ-025 Products and sums SHALL be computed at full OW precision (sign-extended when SIGNED=1) with no overflow or saturation possible.
REQ-026 Elements SHALL be produced in row-major order: j increments first, wrapping N-1->0 and incrementing i.
REQ-027 res_valid SHALL be high only in HOLD; while res_valid=1 and res_ready=0, res_data, res_row and res_col SHALL hold stable.
REQ-028 res_valid SHALL NOT depend combinationally on res_ready.
REQ-029 Latency: first res_valid at cycle N+1 after the start edge; with res_ready tied high, one element every N+1 cycles and a total of N*N*(N+1)+1 cycles from start to done.
REQ-030 done SHALL be high only in FIN; busy SHALL fall in the same cycle that done rises.
REQ-031 A start asserted in the cycle done is high SHALL be ignored; the next start is accepted from IDLE.

Reset
REQ-032 On rst=1 at a clk edge the FSM SHALL go to IDLE; busy, res_valid and done SHALL be 0; res_data, res_row, res_col and acc SHALL be 0.
REQ-033 A and B storage SHALL be cleared to 0 by reset.
REQ-034 Reset mid-operation SHALL abort the operation; no further res_valid SHALL occur until a new start.
REQ-035 rst SHALL have priority over wr_en and start in the same cycle.

Verification
REQ-036 N=4, W=3, unsigned, all A and B elements 7, start, res_ready=1 -> 16 results each 8'hC4 (196), in order (0,0)..(3,3), done 81 cycles after start.
REQ-037 B = identity, A[r][c]=r+c -> C[r][c] = r+c for all 16 elements.
REQ-038 Backpressure: res_ready low for 5 cycles at element (1,2) -> res_valid stays 1 and res_data/res_row/res_col stay stable; the sequence resumes with no element lost or duplicated.
REQ-039 During busy, write A[0][0]=5 and pulse start -> the current results are unaffected, no restart occurs, and A[0][0] keeps its old value.
REQ-040 Reset asserted at element (2,1) -> the next cycle busy=0 and res_valid=0; a following start with reloaded operands gives correct results.
REQ-041 SIGNED=1, all A = 3'b100 (-4), all B = 3 -> every result 8'hD0 (-48).
